// File: rtl/inst_fmt_pkg.sv
// Instruction word format shared by the loader and the fetch/decode stage:
// field widths, bit positions and the loader state encoding.
package inst_fmt_pkg;

    localparam int OPC_W = 5;
    localparam int DST_W = 4;
    localparam int SRC_W = 4;
    localparam int IMM_W = 8;
    localparam int IW    = OPC_W + DST_W + 2 * SRC_W + IMM_W;

    localparam int OPC_MSB = 24;
    localparam int OPC_LSB = 20;
    localparam int DST_MSB = 19;
    localparam int DST_LSB = 16;
    localparam int S1_MSB  = 15;
    localparam int S1_LSB  = 12;
    localparam int S2_MSB  = 11;
    localparam int S2_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VERIFY = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } ld_state_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [DST_W-1:0] destin;
        logic [SRC_W-1:0] source1;
        logic [SRC_W-1:0] source2;
        logic [IMM_W-1:0] imm;
    } inst_fields_t;

    // Decode helper for the fetch side; the struct layout equals the word layout.
    function automatic inst_fields_t unpack_word(input logic [IW-1:0] word);
        return inst_fields_t'(word);
    endfunction

endpackage

// File: rtl/inst_packer.sv
// Purely combinational concatenation of decoded instruction fields into one
// 25-bit instruction word.
module inst_packer
    import inst_fmt_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [DST_W-1:0] Destin,
    input  logic [SRC_W-1:0] Source1,
    input  logic [SRC_W-1:0] Source2,
    input  logic [IMM_W-1:0] Imm,
    output logic [IW-1:0]    word
);

    assign word[OPC_MSB:OPC_LSB] = opcode;
    assign word[DST_MSB:DST_LSB] = Destin;
    assign word[S1_MSB:S1_LSB]   = Source1;
    assign word[S2_MSB:S2_LSB]   = Source2;
    assign word[IMM_MSB:IMM_LSB] = Imm;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-RAM write loader: streams packed words to consecutive addresses,
// then reads the range back and compares XOR checksums.
module inst_mem_loader #(
    parameter int AW        = 8,
    parameter int IW        = 25,
    parameter int MAX_WORDS = 2 ** AW
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            start,
    input  logic [AW-1:0]                   base_addr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [inst_fmt_pkg::OPC_W-1:0]  opcode,
    input  logic [inst_fmt_pkg::DST_W-1:0]  Destin,
    input  logic [inst_fmt_pkg::SRC_W-1:0]  Source1,
    input  logic [inst_fmt_pkg::SRC_W-1:0]  Source2,
    input  logic [inst_fmt_pkg::IMM_W-1:0]  Imm,
    input  logic                            in_last,
    output logic                            mem_we,
    output logic                            mem_re,
    output logic [AW-1:0]                   mem_addr,
    output logic [IW-1:0]                   mem_wdata,
    input  logic [IW-1:0]                   mem_rdata,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            overflow,
    output logic [AW:0]                     word_count
);

    import inst_fmt_pkg::ld_state_t;
    import inst_fmt_pkg::IDLE;
    import inst_fmt_pkg::LOAD;
    import inst_fmt_pkg::VERIFY;
    import inst_fmt_pkg::DONE;
    import inst_fmt_pkg::ERROR;

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(MAX_WORDS - 1);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    ld_state_t     state_reg;
    logic [AW-1:0] base_reg;
    logic [AW:0]   word_count_reg;
    logic [AW:0]   rd_cnt_reg;
    logic [AW:0]   fold_cnt_reg;
    logic [IW-1:0] wr_sum_reg;
    logic [IW-1:0] rd_sum_reg;
    logic          in_ready_reg;
    logic          mem_we_reg;
    logic          mem_re_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [IW-1:0] mem_wdata_reg;
    logic          rd_valid_reg;
    logic          end_pending_reg;
    logic          done_reg;
    logic          error_reg;
    logic          overflow_reg;

    logic [IW-1:0] packed_word;
    logic          beat;
    logic [IW-1:0] rd_sum_next;

    inst_packer u_packer (
        .opcode  (opcode),
        .Destin  (Destin),
        .Source1 (Source1),
        .Source2 (Source2),
        .Imm     (Imm),
        .word    (packed_word)
    );

    assign beat        = in_valid & in_ready_reg;
    assign rd_sum_next = rd_sum_reg ^ mem_rdata;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            word_count_reg  <= '0;
            rd_cnt_reg      <= '0;
            fold_cnt_reg    <= '0;
            wr_sum_reg      <= '0;
            rd_sum_reg      <= '0;
            in_ready_reg    <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_re_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            rd_valid_reg    <= 1'b0;
            end_pending_reg <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (end_pending_reg) begin
                        // The final write is on the bus this cycle; reads start next cycle.
                        end_pending_reg <= 1'b0;
                        mem_we_reg      <= 1'b0;
                        mem_re_reg      <= 1'b1;
                        mem_addr_reg    <= base_reg;
                        rd_cnt_reg      <= ONE;
                        fold_cnt_reg    <= '0;
                        rd_valid_reg    <= 1'b0;
                        state_reg       <= VERIFY;
                    end else if (beat) begin
                        mem_we_reg     <= 1'b1;
                        mem_addr_reg   <= base_reg + word_count_reg[AW-1:0];
                        mem_wdata_reg  <= packed_word;
                        word_count_reg <= word_count_reg + ONE;
                        wr_sum_reg     <= wr_sum_reg ^ packed_word;
                        if (in_last || word_count_reg == LAST_IDX) begin
                            in_ready_reg    <= 1'b0;
                            end_pending_reg <= 1'b1;
                            if (!in_last) begin
                                overflow_reg <= 1'b1;
                            end
                        end
                    end else begin
                        mem_we_reg <= 1'b0;
                    end
                end

                VERIFY: begin
                    rd_valid_reg <= mem_re_reg;
                    if (mem_re_reg) begin
                        if (rd_cnt_reg == word_count_reg) begin
                            mem_re_reg <= 1'b0;
                        end else begin
                            mem_addr_reg <= base_reg + rd_cnt_reg[AW-1:0];
                            rd_cnt_reg   <= rd_cnt_reg + ONE;
                        end
                    end
                    // Read data arrives one cycle after each strobe; compare on the last fold.
                    if (rd_valid_reg) begin
                        rd_sum_reg   <= rd_sum_next;
                        fold_cnt_reg <= fold_cnt_reg + ONE;
                        if (fold_cnt_reg == word_count_reg - ONE) begin
                            if (rd_sum_next == wr_sum_reg && !overflow_reg) begin
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                error_reg <= 1'b1;
                                state_reg <= ERROR;
                            end
                        end
                    end
                end

                default: begin
                    mem_we_reg   <= 1'b0;
                    mem_re_reg   <= 1'b0;
                    rd_valid_reg <= 1'b0;
                    if (start) begin
                        base_reg        <= base_addr;
                        word_count_reg  <= '0;
                        rd_cnt_reg      <= '0;
                        fold_cnt_reg    <= '0;
                        wr_sum_reg      <= '0;
                        rd_sum_reg      <= '0;
                        done_reg        <= 1'b0;
                        error_reg       <= 1'b0;
                        overflow_reg    <= 1'b0;
                        end_pending_reg <= 1'b0;
                        in_ready_reg    <= 1'b1;
                        state_reg       <= LOAD;
                    end
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_re     = mem_re_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = (state_reg == LOAD) || (state_reg == VERIFY);
    assign done       = done_reg;
    assign error      = error_reg;
    assign overflow   = overflow_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader: a RAM model, a write/read scoreboard
// and per-session flag and latency checks.
module tb_inst_mem_loader;

    localparam int AW = 8;
    localparam int IW = 25;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    opcode = '0;
    logic [3:0]    Destin = '0;
    logic [3:0]    Source1 = '0;
    logic [3:0]    Source2 = '0;
    logic [7:0]    Imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic          overflow;
    logic [AW:0]   word_count;

    inst_mem_loader #(.AW(AW), .IW(IW)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .Destin     (Destin),
        .Source1    (Source1),
        .Source2    (Source2),
        .Imm        (Imm),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [IW-1:0] d;
    } wr_t;

    int            nvec = 0;
    int            nerr = 0;
    int            cyc = 0;
    int            last_we_cyc = 0;
    int            first_we_cyc = 0;
    int            wr_in_sess = 0;
    int            rd_n = 0;
    bit            corrupt = 1'b0;
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [IW-1:0] ram [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] model_word(input int op, input int d, input int s1,
                                                 input int s2, input int imm);
        int w;
        w = op * (1 << 20) + d * (1 << 16) + s1 * (1 << 12) + s2 * (1 << 8) + imm;
        return w[IW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with registered read; optionally corrupts bit 0 of the second read of a session.
    always @(posedge clk) begin
        if (start) rd_n <= 0;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) begin
            rd_n      <= rd_n + 1;
            mem_rdata <= ram[mem_addr] ^ ((corrupt && rd_n == 1) ? 25'd1 : 25'd0);
        end
    end

    // Monitor: pops expectations whenever the DUT drives a RAM strobe.
    always @(negedge clk) begin
        if (!Reset) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
        end else begin
            if (start) wr_in_sess = 0;
            if (mem_we || mem_re) chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            if (mem_we) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
                    chk("wr_data", {7'd0, mem_wdata}, {7'd0, e.d});
                end
                if (wr_in_sess == 0) first_we_cyc = cyc;
                wr_in_sess++;
                last_we_cyc = cyc;
            end
            if (mem_re) begin
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_rd_q.pop_front();
                    chk("rd_addr", {24'd0, mem_addr}, {24'd0, ea});
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [7:0] imm, input bit last);
        bit ok;
        logic r;
        ok       = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        Destin   = d;
        Source1  = s1;
        Source2  = s2;
        Imm      = imm;
        in_last  = last;
        for (int t = 0; t < 50; t++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // directed=1 sends the single fixed beat with a literal expected word.
    task automatic run_session(input logic [AW-1:0] b, input int n, input bit use_last,
                               input bit corr, input bit gaps, input bit directed,
                               input bit check_stream);
        bit exp_ovf;
        bit exp_ok;
        bit finished;
        logic [AW-1:0] a;
        exp_ovf = !use_last;
        exp_ok  = !corr && !exp_ovf;
        corrupt = corr;
        do_start(b);
        chk("start_clear", {20'd0, done, error, overflow, word_count}, 32'd0);
        chk("busy_load", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_rd_q.push_back(a);
        end
        for (int i = 0; i < n; i++) begin
            logic [4:0] op;
            logic [3:0] d, s1, s2;
            logic [7:0] imm;
            wr_t e;
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
            if (directed) begin
                op = 5'h03; d = 4'h1; s1 = 4'h2; s2 = 4'h3; imm = 8'h7F;
                e.d = 25'h031237F;
            end else begin
                op  = 5'($urandom);
                d   = 4'($urandom);
                s1  = 4'($urandom);
                s2  = 4'($urandom);
                imm = 8'($urandom);
                e.d = model_word(int'(op), int'(d), int'(s1), int'(s2), int'(imm));
            end
            e.a = b + AW'(i);
            exp_wr_q.push_back(e);
            send_beat(op, d, s1, s2, imm, use_last && (i == n - 1));
        end
        chk("ready_drop", {31'd0, in_ready}, 32'd0);
        finished = 1'b0;
        for (int t = 0; t < n + 40; t++) begin
            if (done || error) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!finished) chk("session_timeout", 32'd0, 32'd1);
        chk("latency", 32'(cyc - last_we_cyc), 32'(n + 2));
        chk("done", {31'd0, done}, {31'd0, exp_ok});
        chk("error", {31'd0, error}, {31'd0, !exp_ok});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("word_count", {23'd0, word_count}, 32'(n));
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("writes_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("reads_drained", 32'(exp_rd_q.size()), 32'd0);
        if (check_stream) chk("stream_span", 32'(last_we_cyc - first_we_cyc), 32'(n - 1));
        $display("session base=%0h n=%0d last=%0d corrupt=%0d -> done=%0d error=%0d ovf=%0d",
                 b, n, use_last, corr, done, error, overflow);
        corrupt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_t e;
        // Outputs while reset is held from time zero.
        #2;
        chk("reset_outputs", {mem_we, mem_re, in_ready, busy, done, error, overflow, word_count},
            32'd0);
        @(posedge clk); #3;
        Reset = 1'b1;
        @(posedge clk); #1;

        // Abort mid-LOAD while a write strobe is on the bus.
        do_start(8'h40);
        for (int i = 0; i < 2; i++) begin
            e.a = 8'h40 + 8'(i);
            e.d = model_word(i + 1, 2, 3, 4, 8'h55);
            exp_wr_q.push_back(e);
            send_beat(5'(i + 1), 4'd2, 4'd3, 4'd4, 8'h55, 1'b0);
        end
        chk("we_before_reset", {31'd0, mem_we}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("we_async_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_outputs", {mem_we, mem_re, in_ready, busy, done, error, overflow, word_count},
            32'd0);
        chk("abort_addr_data", {mem_addr, mem_wdata[23:0]}, 32'd0);
        @(posedge clk); #3;
        Reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'(dut.state_reg), 32'(inst_fmt_pkg::IDLE));
        chk("ready_idle", {30'd0, in_ready, busy}, 32'd0);
        $display("reset abort checked");

        run_session(8'h10, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_session(8'h20, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_session(8'hFE, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_session(8'($urandom), 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_session(8'h00, 256, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            int n;
            bit corr;
            n    = $urandom_range(1, 24);
            corr = (n >= 2) && ($urandom_range(0, 3) == 0);
            run_session(8'($urandom), n, 1'b1, corr, 1'b1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
